// File: rtl/wb_sdr_pkg.sv
// Shared types and constants for the Wishbone-to-SDRAM-controller bridge.
package wb_sdr_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WDATA = 3'd2,
        RDATA = 3'd3,
        ACK   = 3'd4
    } wb_sdr_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_sdr_wdog.sv
// Transfer watchdog: counts while enabled and flags the cycle in which the
// count sits at TIMEOUT-1; clearing reloads zero.
module wb_sdr_wdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Count advances every enabled cycle, so this is high for one cycle only.
    assign o_expired = i_en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_sdr_bridge.sv
// Wishbone classic slave that turns each single-beat cycle into a one-word
// request on the SDRAM controller application interface.
module wb_sdr_bridge
    import wb_sdr_pkg::*;
#(
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_W-1:0]     wb_addr_i,
    input  logic [DATA_W-1:0]     wb_dat_i,
    input  logic [DATA_W/8-1:0]   wb_sel_i,
    input  logic [2:0]            wb_cti_i,
    output logic [DATA_W-1:0]     wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  app_req_o,
    output logic [ADDR_W-3:0]     app_req_addr_o,
    output logic [7:0]            app_req_len_o,
    output logic                  app_req_wr_n_o,
    input  logic                  app_req_ack_i,
    output logic [DATA_W-1:0]     app_wr_data_o,
    output logic [DATA_W/8-1:0]   app_wr_en_n_o,
    input  logic                  app_wr_next_i,
    input  logic [DATA_W-1:0]     app_rd_data_i,
    input  logic                  app_rd_valid_i
);

    localparam int SEL_W = DATA_W / 8;

    wb_sdr_state_e r_state, w_state_nxt;

    logic              r_req, r_ack, r_err, r_wr_n, r_abort;
    logic [ADDR_W-3:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic [SEL_W-1:0]  r_en_n;

    logic w_req_nxt, w_ack_nxt, w_err_nxt, w_abort_nxt;
    logic w_accept, w_rd_cap, w_busy, w_wdog_clr, w_expired;
    logic w_unused;

    // Every cycle type is serviced as an independent single beat.
    assign w_unused   = ^{wb_cti_i, wb_addr_i[1:0]};
    assign w_busy     = (r_state == REQ) || (r_state == WDATA) || (r_state == RDATA);
    assign w_wdog_clr = (r_state == IDLE);

    wb_sdr_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .i_clk     (wb_clk_i),
        .i_rst     (wb_rst_i),
        .i_clr     (w_wdog_clr),
        .i_en      (w_busy),
        .o_expired (w_expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_abort_nxt = r_abort;
        w_accept    = 1'b0;
        w_rd_cap    = 1'b0;
        case (r_state)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    w_accept    = 1'b1;
                    w_req_nxt   = 1'b1;
                    w_abort_nxt = 1'b0;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (w_expired) begin
                    w_req_nxt   = 1'b0;
                    w_err_nxt   = wb_cyc_i;
                    w_state_nxt = IDLE;
                end else if (app_req_ack_i) begin
                    // Once accepted downstream the transfer must run to completion.
                    w_req_nxt   = 1'b0;
                    w_abort_nxt = !wb_cyc_i;
                    w_state_nxt = r_wr_n ? RDATA : WDATA;
                end else if (!wb_cyc_i) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            WDATA, RDATA: begin
                if (w_expired) begin
                    w_err_nxt   = wb_cyc_i && !r_abort;
                    w_state_nxt = IDLE;
                end else begin
                    if (!wb_cyc_i) w_abort_nxt = 1'b1;
                    if ((r_state == WDATA) ? app_wr_next_i : app_rd_valid_i) begin
                        w_rd_cap    = (r_state == RDATA);
                        w_state_nxt = (r_abort || !wb_cyc_i) ? IDLE : ACK;
                    end
                end
            end
            ACK: begin
                w_ack_nxt   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_req   <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_abort <= 1'b0;
            r_wr_n  <= 1'b1;
            r_addr  <= '0;
            r_wdata <= '0;
            r_en_n  <= '1;
            r_rdata <= '0;
        end else begin
            r_req   <= w_req_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_abort <= w_abort_nxt;
            if (w_accept) begin
                r_wr_n  <= !wb_we_i;
                r_addr  <= wb_addr_i[ADDR_W-1:2];
                r_wdata <= wb_dat_i;
                r_en_n  <= ~wb_sel_i;
            end
            if (w_rd_cap) r_rdata <= app_rd_data_i;
        end
    end

    assign app_req_o      = r_req;
    assign app_req_addr_o = r_addr;
    assign app_req_len_o  = 8'd1;
    assign app_req_wr_n_o = r_wr_n;
    assign app_wr_data_o  = r_wdata;
    assign app_wr_en_n_o  = r_en_n;
    assign wb_dat_o       = r_rdata;
    assign wb_ack_o       = r_ack;
    assign wb_err_o       = r_err;

endmodule

// File: tb/tb_wb_sdr_bridge.sv
// Randomized scoreboard bench for wb_sdr_bridge with a word-memory reference model.
module tb_wb_sdr_bridge;
    import wb_sdr_pkg::*;

    localparam int TO = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [25:0] wb_addr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [2:0]  wb_cti_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic        app_req_o;
    logic [23:0] app_req_addr_o;
    logic [7:0]  app_req_len_o;
    logic        app_req_wr_n_o;
    logic        app_req_ack_i;
    logic [31:0] app_wr_data_o;
    logic [3:0]  app_wr_en_n_o;
    logic        app_wr_next_i;
    logic [31:0] app_rd_data_i;
    logic        app_rd_valid_i;

    wb_sdr_bridge #(.ADDR_W(26), .DATA_W(32), .TIMEOUT(TO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_cti_i(wb_cti_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .app_req_o(app_req_o), .app_req_addr_o(app_req_addr_o), .app_req_len_o(app_req_len_o),
        .app_req_wr_n_o(app_req_wr_n_o), .app_req_ack_i(app_req_ack_i),
        .app_wr_data_o(app_wr_data_o), .app_wr_en_n_o(app_wr_en_n_o),
        .app_wr_next_i(app_wr_next_i), .app_rd_data_i(app_rd_data_i),
        .app_rd_valid_i(app_rd_valid_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model[16];
    logic [31:0] sdram[16];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Monitor: every ack/err must match the oldest outstanding expectation.
    always @(negedge wb_clk_i) begin
        resp_t r;
        if (!wb_rst_i && (wb_ack_o || wb_err_o)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got ack=%0b err=%0b expected none", wb_ack_o, wb_err_o);
            end else begin
                r = exp_q.pop_front();
                check("resp_is_err", {wb_ack_o, wb_err_o}, r.err ? 2'b01 : 2'b10);
                if (r.rd && !r.err) check("rd_data", wb_dat_o, r.data);
            end
        end
    end

    task automatic tick;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_req"},   app_req_o, 0);
        check({tag, "_ack"},   wb_ack_o, 0);
        check({tag, "_err"},   wb_err_o, 0);
        check({tag, "_dat"},   wb_dat_o, 0);
        check({tag, "_wdat"},  app_wr_data_o, 0);
        check({tag, "_addr"},  app_req_addr_o, 0);
        check({tag, "_wr_n"},  app_req_wr_n_o, 1);
        check({tag, "_en_n"},  app_wr_en_n_o, 4'hF);
        check({tag, "_len"},   app_req_len_o, 1);
    endtask

    task automatic drive(input bit we, input int word, input logic [1:0] lo,
                         input logic [31:0] wd, input logic [3:0] sel);
        wb_cyc_i  = 1'b1;
        wb_stb_i  = 1'b1;
        wb_we_i   = we;
        wb_addr_i = {24'(word), lo};
        wb_dat_i  = wd;
        wb_sel_i  = sel;
        case ($urandom_range(0, 2))
            0:       wb_cti_i = CTI_CLASSIC;
            1:       wb_cti_i = CTI_INCR;
            default: wb_cti_i = CTI_EOB;
        endcase
    endtask

    task automatic xfer(input bit we, input int word, input logic [1:0] lo, input logic [31:0] wd,
                        input logic [3:0] sel, input int rdly, input int ddly, input bit drop);
        resp_t       r;
        logic [3:0]  en_exp;
        int          dw, n;
        bit          got;
        en_exp = ~sel;
        r.err  = 1'b0;
        r.rd   = !we;
        r.data = model[word];
        if (we) model[word] = merge(model[word], wd, sel);
        if (!drop) exp_q.push_back(r);
        drive(we, word, lo, wd, sel);
        tick();
        check("req_rise", app_req_o, 1);
        check("req_addr", app_req_addr_o, 24'(word));
        check("req_wr_n", app_req_wr_n_o, !we);
        if (we) begin
            check("wr_data", app_wr_data_o, wd);
            check("wr_en_n", app_wr_en_n_o, en_exp);
        end
        dw = int'(app_req_addr_o[3:0]);
        repeat (rdly) begin
            tick();
            check("req_hold", app_req_o, 1);
        end
        app_req_ack_i = 1'b1;
        tick();
        app_req_ack_i = 1'b0;
        check("req_drop", app_req_o, 0);
        if (drop) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
        end
        repeat (ddly) tick();
        if (we) begin
            check("en_n_hold", app_wr_en_n_o, en_exp);
            sdram[dw]     = merge(sdram[dw], app_wr_data_o, ~app_wr_en_n_o);
            app_wr_next_i = 1'b1;
        end else begin
            app_rd_data_i  = sdram[dw];
            app_rd_valid_i = 1'b1;
        end
        tick();
        app_wr_next_i  = 1'b0;
        app_rd_valid_i = 1'b0;
        app_rd_data_i  = $urandom;
        if (!drop) begin
            n   = 0;
            got = 1'b0;
            while (!got && n < 8) begin
                tick();
                n++;
                got = wb_ack_o || wb_err_o;
            end
            check("ack_latency", n, 1);
            check("no_reissue", app_req_o, 0);
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
        end else begin
            repeat (4) tick();
            check("abort_idle", app_req_o, 0);
        end
        tick();
    endtask

    task automatic timeout_xfer(input int word);
        resp_t r;
        int    n;
        r.err  = 1'b1;
        r.rd   = 1'b0;
        r.data = '0;
        exp_q.push_back(r);
        drive(1'b1, word, 2'b00, $urandom, 4'hF);
        tick();
        n = 0;
        while (!wb_err_o && n < TO + 8) begin
            tick();
            n++;
        end
        check("timeout_latency", n, TO);
        check("timeout_req_low", app_req_o, 0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        repeat (2) tick();
    endtask

    task automatic reset_mid_read(input int word);
        drive(1'b0, word, 2'b00, '0, 4'hF);
        tick();
        app_req_ack_i = 1'b1;
        tick();
        app_req_ack_i = 1'b0;
        repeat (2) tick();
        wb_rst_i = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        tick();
        wb_rst_i = 1'b0;
        chk_reset("midrd");
        app_rd_data_i  = 32'hA5A5_5A5A;
        app_rd_valid_i = 1'b1;
        tick();
        app_rd_valid_i = 1'b0;
        repeat (4) tick();
        check("dat_after_rst", wb_dat_o, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        wb_rst_i = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_addr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_cti_i = CTI_CLASSIC;
        app_req_ack_i = 1'b0; app_wr_next_i = 1'b0;
        app_rd_data_i = '0; app_rd_valid_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            sdram[i] = model[i];
        end
        model[8] = 32'h1234_5678;
        sdram[8] = 32'h1234_5678;
        repeat (3) tick();
        chk_reset("por");
        wb_rst_i = 1'b0;
        tick();

        xfer(1'b1, 4, 2'b00, 32'hDEAD_BEEF, 4'b1111, 0, 0, 1'b0);
        xfer(1'b0, 8, 2'b00, 32'h0, 4'b1111, 0, 5, 1'b0);
        xfer(1'b1, 2, 2'b11, 32'hCAFE_F00D, 4'b0101, 2, 3, 1'b0);
        xfer(1'b0, 2, 2'b01, 32'h0, 4'b1111, 1, 1, 1'b0);
        xfer(1'b1, 3, 2'b00, 32'h1111_2222, 4'b0000, 0, 0, 1'b0);
        xfer(1'b0, 4, 2'b10, 32'h0, 4'b1111, 0, 0, 1'b0);
        timeout_xfer(1);
        xfer(1'b0, 5, 2'b00, 32'h0, 4'b1111, 0, 3, 1'b1);
        xfer(1'b1, 5, 2'b00, 32'h0BAD_CAFE, 4'b1111, 0, 0, 1'b0);
        xfer(1'b0, 5, 2'b00, 32'h0, 4'b1111, 0, 0, 1'b0);
        reset_mid_read(6);

        for (int i = 0; i < 40; i++) begin
            xfer(1'($urandom_range(0, 1)), $urandom_range(0, 15), 2'($urandom_range(0, 3)),
                 $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 6), $urandom_range(0, 7) == 0);
        end
        for (int w = 0; w < 16; w++) xfer(1'b0, w, 2'b00, 32'h0, 4'hF, 0, 0, 1'b0);

        repeat (3) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
